// File: rtl/decode_stage.sv
// decode_stage: registered multi-lane instruction decoder with a one-entry skid buffer.
//
// The file starts with the instruction and micro-op type packages (instr_pkg, uop_pkg).
// The decode_stage module follows them.
//
// Ports:
//   clk, rst          single clock; synchronous active-high reset
//   flush             drops every held bundle and the bundle offered in the same cycle
//   in_valid/in_ready input bundle handshake; in_ready comes straight from a flop
//   in_lane_valid     per-lane valid mask of the incoming bundle
//   in_enc            LANES x 32-bit encodings, lane 0 in the LSBs
//   out_valid/out_ready output bundle handshake
//   out_lane_valid    per-lane valid after exception truncation
//   out_dec           LANES x uop_pkg::dec_t, lane 0 in the LSBs
//   fault_cnt         saturating count of accepted bundles that hold a decode fault
//
// Optional feature: defining DECODE_STAGE_ONEHOT_FU_EN adds the out_fu_mask port.
// It carries a per-lane one-hot {NONE, INTALU, rsvd, rsvd} vector, registered alongside out_dec.

package instr_pkg;
  localparam logic [6:0] OP_ARITHI = 7'h13;
  localparam logic [6:0] OP_ARITH  = 7'h33;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } enc_t;
endpackage

package uop_pkg;
  typedef enum logic {EX_NONE = 1'b0, EX_DECODE = 1'b1} ex_e;
  typedef enum logic [1:0] {FU_NONE = 2'd0, FU_INTALU = 2'd1} fu_e;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_XOR, ALU_SHL, ALU_SHR, ALU_SHRA
  } alu_op_e;

  typedef struct packed {
    ex_e         ex;
    fu_e         fu;
    alu_op_e     op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        imm_valid;
    logic [31:0] imm;
  } dec_t;
endpackage

module decode_stage #(
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [LANES-1:0]                      in_lane_valid,
  input  logic [LANES*32-1:0]                   in_enc,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [LANES-1:0]                      out_lane_valid,
  output logic [LANES*$bits(uop_pkg::dec_t)-1:0] out_dec,
`ifdef DECODE_STAGE_ONEHOT_FU_EN
  output logic [LANES*4-1:0]                    out_fu_mask,
`endif
  output logic [CNT_W-1:0]                      fault_cnt
);

  import uop_pkg::*;

  localparam int unsigned DecW = $bits(dec_t);

  function automatic dec_t decode_lane(instr_pkg::enc_t enc);
    dec_t d;
    d = '0;
    if (enc.opcode == instr_pkg::OP_ARITH || enc.opcode == instr_pkg::OP_ARITHI) begin
      d.fu  = FU_INTALU;
      d.op  = alu_op_e'(enc.funct3);
      d.rd  = enc.rd;
      d.rs1 = enc.rs1;
      if (enc.opcode == instr_pkg::OP_ARITHI) begin
        d.imm_valid = 1'b1;
        // The I-immediate occupies the funct7/rs2 bit positions.
        d.imm       = {{20{enc.funct7[6]}}, enc.funct7, enc.rs2};
      end else begin
        d.rs2 = enc.rs2;
      end
    end else begin
      d.ex = EX_DECODE;
    end
    return d;
  endfunction

  // Per-lane decode and truncation behind the first faulting lane
  dec_t                    lane_dec [LANES];
  logic [LANES-1:0]        new_lv;
  logic [LANES*DecW-1:0]   new_dec;
  logic                    new_fault;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_dec[i] = decode_lane(in_enc[i*32 +: 32]);
    end
  end

  always_comb begin
    new_lv    = '0;
    new_dec   = '0;
    new_fault = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      // The faulting lane itself stays valid; everything above it is dropped.
      if (in_lane_valid[i] && !new_fault) begin
        new_lv[i]              = 1'b1;
        new_dec[i*DecW +: DecW] = lane_dec[i];
        if (lane_dec[i].ex == EX_DECODE) begin
          new_fault = 1'b1;
        end
      end
    end
  end

`ifdef DECODE_STAGE_ONEHOT_FU_EN
  logic [LANES*4-1:0] new_mask;
  logic [LANES*4-1:0] out_mask_q, out_mask_d, skid_mask_q, skid_mask_d;

  always_comb begin
    new_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if (new_lv[i]) begin
        if (lane_dec[i].fu == FU_NONE) begin
          new_mask[i*4 +: 4] = 4'b1000;
        end else if (lane_dec[i].fu == FU_INTALU) begin
          new_mask[i*4 +: 4] = 4'b0100;
        end
      end
    end
  end

  assign out_fu_mask = out_mask_q;
`endif

  // Output register plus one skid entry
  logic                  out_valid_q, out_valid_d;
  logic [LANES-1:0]      out_lv_q, out_lv_d;
  logic [LANES*DecW-1:0] out_dec_q, out_dec_d;
  logic                  skid_full_q, skid_full_d;
  logic [LANES-1:0]      skid_lv_q, skid_lv_d;
  logic [LANES*DecW-1:0] skid_dec_q, skid_dec_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic in_fire, load, take;

  assign in_ready = !skid_full_q;
  assign in_fire  = in_valid && in_ready && !flush;
  // Bundles with no valid lane are accepted but never stored.
  assign load     = in_fire && (|in_lane_valid);
  assign take     = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_lv_d    = out_lv_q;
    out_dec_d   = out_dec_q;
    skid_full_d = skid_full_q;
    skid_lv_d   = skid_lv_q;
    skid_dec_d  = skid_dec_q;
    cnt_d       = cnt_q;
`ifdef DECODE_STAGE_ONEHOT_FU_EN
    out_mask_d  = out_mask_q;
    skid_mask_d = skid_mask_q;
`endif
    if (flush) begin
      out_valid_d = 1'b0;
      out_lv_d    = '0;
      skid_full_d = 1'b0;
    end else begin
      if (take) begin
        if (skid_full_q) begin
          out_lv_d    = skid_lv_q;
          out_dec_d   = skid_dec_q;
          skid_full_d = 1'b0;
`ifdef DECODE_STAGE_ONEHOT_FU_EN
          out_mask_d  = skid_mask_q;
`endif
        end else if (load) begin
          out_lv_d   = new_lv;
          out_dec_d  = new_dec;
`ifdef DECODE_STAGE_ONEHOT_FU_EN
          out_mask_d = new_mask;
`endif
        end else begin
          out_valid_d = 1'b0;
          out_lv_d    = '0;
        end
      end else if (load) begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_lv_d    = new_lv;
          out_dec_d   = new_dec;
`ifdef DECODE_STAGE_ONEHOT_FU_EN
          out_mask_d  = new_mask;
`endif
        end else begin
          skid_full_d = 1'b1;
          skid_lv_d   = new_lv;
          skid_dec_d  = new_dec;
`ifdef DECODE_STAGE_ONEHOT_FU_EN
          skid_mask_d = new_mask;
`endif
        end
      end
      if (in_fire && new_fault && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_lv_q    <= '0;
      out_dec_q   <= '0;
      skid_full_q <= 1'b0;
      skid_lv_q   <= '0;
      skid_dec_q  <= '0;
      cnt_q       <= '0;
`ifdef DECODE_STAGE_ONEHOT_FU_EN
      out_mask_q  <= '0;
      skid_mask_q <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_lv_q    <= out_lv_d;
      out_dec_q   <= out_dec_d;
      skid_full_q <= skid_full_d;
      skid_lv_q   <= skid_lv_d;
      skid_dec_q  <= skid_dec_d;
      cnt_q       <= cnt_d;
`ifdef DECODE_STAGE_ONEHOT_FU_EN
      out_mask_q  <= out_mask_d;
      skid_mask_q <= skid_mask_d;
`endif
    end
  end

  assign out_valid      = out_valid_q;
  assign out_lane_valid = out_lv_q;
  assign out_dec        = out_dec_q;
  assign fault_cnt      = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage.
// The reference model treats the stage as a two-deep FIFO of decoded bundles.
// A second instance with CNT_W=2 shares the inputs and exercises counter saturation.
module tb_decode_stage;
  import uop_pkg::*;

  localparam int unsigned LANES = 2;
  localparam int unsigned DEC_W = $bits(dec_t);

  logic                    clk, rst, flush, in_valid, out_ready;
  logic [LANES-1:0]        in_lane_valid;
  logic [LANES*32-1:0]     in_enc;
  logic                    in_ready, out_valid;
  logic [LANES-1:0]        out_lane_valid;
  logic [LANES*DEC_W-1:0]  out_dec;
  logic [15:0]             fault_cnt;
  logic                    s_in_ready, s_out_valid;
  logic [LANES-1:0]        s_out_lane_valid;
  logic [LANES*DEC_W-1:0]  s_out_dec;
  logic [1:0]              s_fault_cnt;
`ifdef DECODE_STAGE_ONEHOT_FU_EN
  logic [LANES*4-1:0]      out_fu_mask, s_out_fu_mask;
`endif

  decode_stage #(.LANES(LANES), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_enc(in_enc), .out_valid(out_valid),
    .out_ready(out_ready), .out_lane_valid(out_lane_valid), .out_dec(out_dec),
`ifdef DECODE_STAGE_ONEHOT_FU_EN
    .out_fu_mask(out_fu_mask),
`endif
    .fault_cnt(fault_cnt)
  );

  decode_stage #(.LANES(LANES), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_lane_valid(in_lane_valid), .in_enc(in_enc), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_lane_valid(s_out_lane_valid), .out_dec(s_out_dec),
`ifdef DECODE_STAGE_ONEHOT_FU_EN
    .out_fu_mask(s_out_fu_mask),
`endif
    .fault_cnt(s_fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0]       lv;
    logic [LANES*DEC_W-1:0] dec;
    logic [LANES*4-1:0]     mask;
    logic                   fault;
  } bundle_t;

  bundle_t     q[$];
  int unsigned model_cnt, sat_model;
  int          checks, errors;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic alu_op_e op_for(input logic [2:0] f3);
    case (f3)
      3'd0: return ALU_ADD;
      3'd1: return ALU_SUB;
      3'd2: return ALU_OR;
      3'd3: return ALU_AND;
      3'd4: return ALU_XOR;
      3'd5: return ALU_SHL;
      3'd6: return ALU_SHR;
      default: return ALU_SHRA;
    endcase
  endfunction

  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t d;
    d = '0;
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
      d.fu  = FU_INTALU;
      d.op  = op_for(w[14:12]);
      d.rd  = w[11:7];
      d.rs1 = w[19:15];
      if (w[6:0] == 7'h13) begin
        d.imm_valid = 1'b1;
        d.imm       = 32'($signed(w[31:20]));
      end else begin
        d.rs2 = w[24:20];
      end
    end else begin
      d.ex = EX_DECODE;
    end
    return d;
  endfunction

  function automatic bundle_t ref_bundle(input logic [LANES-1:0] lv,
                                         input logic [LANES*32-1:0] enc);
    bundle_t b;
    dec_t    d;
    b.lv = '0; b.dec = '0; b.mask = '0; b.fault = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (lv[i] && !b.fault) begin
        d = ref_dec(enc[i*32 +: 32]);
        b.lv[i] = 1'b1;
        b.dec[i*DEC_W +: DEC_W] = d;
        b.mask[i*4 +: 4] = (d.ex == EX_DECODE) ? 4'b1000 : 4'b0100;
        if (d.ex == EX_DECODE) b.fault = 1'b1;
      end
    end
    return b;
  endfunction

  function automatic logic [31:0] enc_i(input int f3, input int rd, input int rs1,
                                        input logic [11:0] imm);
    return {imm, 5'(rs1), 3'(f3), 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input int f3, input int rd, input int rs1, input int rs2);
    return {7'h00, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(2))
      0: r[6:0] = 7'h33;
      1: r[6:0] = 7'h13;
      default: ;
    endcase
    return r;
  endfunction

  task automatic check_state();
    check("in_ready", in_ready, (q.size() < 2));
    check("out_valid", out_valid, (q.size() > 0));
    if (q.size() > 0) begin
      check("out_lane_valid", out_lane_valid, q[0].lv);
      check("out_dec", out_dec, q[0].dec);
`ifdef DECODE_STAGE_ONEHOT_FU_EN
      check("out_fu_mask", out_fu_mask, q[0].mask);
`endif
    end
    check("fault_cnt", fault_cnt, model_cnt);
    check("sat_fault_cnt", s_fault_cnt, sat_model);
  endtask

  task automatic step(input logic iv, input logic [LANES-1:0] lv, input logic [LANES*32-1:0] enc,
                      input logic ordy, input logic fl);
    bit      rdy, ovalid;
    bundle_t b;
    check_state();
    in_valid = iv; in_lane_valid = lv; in_enc = enc; out_ready = ordy; flush = fl;
    rdy    = (q.size() < 2);
    ovalid = (q.size() > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (ovalid && ordy) void'(q.pop_front());
      if (iv && rdy) begin
        b = ref_bundle(lv, enc);
        if (|lv) q.push_back(b);
        if (b.fault) begin
          if (model_cnt < 65535) model_cnt++;
          if (sat_model < 3) sat_model++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_lane_valid = '0; in_enc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    q.delete(); model_cnt = 0; sat_model = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] bad;
  dec_t        d0, d1;
  int          exp_seq[5];

  initial begin
    checks = 0; errors = 0;
    bad = 32'h0000_007F;
    exp_seq = '{1, 2, 3, 3, 3};
    do_reset();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_lane_valid", out_lane_valid, 2'b00);
    check("rst_out_dec", out_dec, '0);
    check("rst_fault_cnt", fault_cnt, 16'd0);
    check("rst_in_ready", in_ready, 1'b1);

    // Single lane ARITHI ADD with an all-ones immediate
    step(1, 2'b01, {32'h0, enc_i(0, 1, 2, 12'hFFF)}, 1, 0);
    d0 = dec_t'(out_dec[DEC_W-1:0]);
    check("t1_valid", out_valid, 1'b1);
    check("t1_lv", out_lane_valid, 2'b01);
    check("t1_fu", d0.fu, FU_INTALU);
    check("t1_op", d0.op, ALU_ADD);
    check("t1_immv", d0.imm_valid, 1'b1);
    check("t1_imm", d0.imm, 32'hFFFF_FFFF);
    check("t1_rs2", d0.rs2, 5'd0);

    // Full bundle
    step(1, 2'b11, {enc_i(4, 6, 7, 12'h07F), enc_r(1, 3, 4, 5)}, 1, 0);
    d0 = dec_t'(out_dec[DEC_W-1:0]);
    d1 = dec_t'(out_dec[2*DEC_W-1:DEC_W]);
    check("t2_lv", out_lane_valid, 2'b11);
    check("t2_imm1", d1.imm, 32'h0000_007F);
    check("t2_rs2_0", d0.rs2, 5'd5);
    check("t2_cnt", fault_cnt, 16'd0);

    // Truncation behind a faulting lane 0
    step(1, 2'b11, {enc_r(0, 1, 1, 1), bad}, 1, 0);
    d0 = dec_t'(out_dec[DEC_W-1:0]);
    check("t3_lv", out_lane_valid, 2'b01);
    check("t3_ex0", d0.ex, EX_DECODE);
    check("t3_dec1", out_dec[2*DEC_W-1:DEC_W], '0);
    check("t3_cnt", fault_cnt, 16'd1);

    // Empty-mask bundle is swallowed
    step(1, 2'b00, {enc_r(2, 1, 1, 1), enc_r(3, 2, 2, 2)}, 1, 0);
    check("t4_drop", out_valid, 1'b0);

    // Backpressure: two accepted, third refused, then drain in order
    step(1, 2'b11, {enc_r(2, 8, 9, 10), enc_r(3, 11, 12, 13)}, 0, 0);
    step(1, 2'b01, {32'h0, enc_i(5, 14, 15, 12'h800)}, 0, 0);
    check("bp_in_ready", in_ready, 1'b0);
    step(1, 2'b11, {enc_r(6, 16, 17, 18), enc_r(7, 19, 20, 21)}, 0, 0);
    repeat (3) step(0, 2'b00, '0, 1, 0);

    // Flush with output and skid full, faulting bundle offered alongside
    step(1, 2'b11, {enc_r(0, 1, 2, 3), enc_r(1, 4, 5, 6)}, 0, 0);
    step(1, 2'b11, {enc_r(2, 7, 8, 9), enc_r(3, 10, 11, 12)}, 0, 0);
    step(1, 2'b01, {32'h0, bad}, 0, 1);
    check("fl_out_valid", out_valid, 1'b0);
    check("fl_in_ready", in_ready, 1'b1);
    check("fl_cnt", fault_cnt, 16'd1);
    repeat (2) step(0, 2'b00, '0, 1, 0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(3) != 0), LANES'($urandom), {rnd_instr(), rnd_instr()},
           ($urandom_range(2) != 0), ($urandom_range(19) == 0));
    end

    // Reset mid-stream, then saturate the 2-bit counter
    step(1, 2'b11, {enc_r(0, 1, 2, 3), enc_r(1, 4, 5, 6)}, 0, 0);
    do_reset();
    check("rst2_out_valid", out_valid, 1'b0);
    for (int n = 0; n < 5; n++) begin
      step(1, 2'b01, {32'h0, bad}, 1, 0);
      check("sat_seq", s_fault_cnt, exp_seq[n]);
    end
    step(0, 2'b00, '0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, multi-lane successor to the combinational instruction decoder.
- Accepts a bundle of up to LANES encoded instructions per cycle and decodes each lane to Uop::dec_t.
- Registers the result behind a valid/ready handshake with a one-entry skid buffer, so fetch and rename decouple without a combinational ready path.
- Adds per-bundle exception truncation, flush, and a saturating decode-fault counter.

Parameters:
- LANES, 2, instructions per bundle (1..4).
- CNT_W, 16, width of decode-fault counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flush  input  1  discard all held and incoming bundles this cycle
- in_valid  input  1  input bundle valid
- in_ready  output  1  stage can accept a bundle
- in_lane_valid  input  LANES  per-lane valid mask
- in_enc  input  LANES*32  Instr::enc_t per lane, lane 0 in LSBs
- out_valid  output  1  output bundle valid
- out_ready  input  1  consumer accepts the bundle
- out_lane_valid  output  LANES  per-lane valid after truncation
- out_dec  output  LANES*$bits(Uop::dec_t)  decoded uop per lane
- fault_cnt  output  CNT_W  saturating count of bundles containing a decode fault

Behaviour:
- Reset: synchronous and active-high; the design has one clock.
  - out_valid=0, out_lane_valid=0, out_dec=0, fault_cnt=0, skid empty.
  - in_ready=1 from the first cycle after rst deasserts.
- Lane decode is identical per lane:
  - OP_ARITH/OP_ARITHI → FU_INTALU. funct3 maps to ADD/SUB/OR/AND/XOR/SHL/SHR/SHRA.
  - rd and rs1 are taken from the encoding.
  - ARITHI: immValid=1 and imm = sign-extended 12-bit I-immediate to 32 bits; rs2=0.
  - ARITH: rs2 taken from the encoding, immValid=0.
  - Unknown op or funct3: ex=EX_DECODE, fu=FU_NONE, all other fields 0.
- Lanes with in_lane_valid=0 decode to all-zero dec with ex=EX_NONE.
- Truncation:
  - Let k be the lowest valid lane with ex=EX_DECODE.
  - Lane k is kept, carrying the exception. Lanes above k are marked invalid and their dec is forced to 0.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Latency is 1 cycle: a bundle accepted in cycle N is on the outputs in cycle N+1.
- Skid buffer:
  - in_ready = !skid_full, registered.
  - If the output register holds an untaken bundle and a new bundle is accepted, the new bundle goes to skid and skid_full is set.
  - When the output is taken and skid is full, skid moves to the output register and skid_full clears.
  - Simultaneous output take and input accept with skid empty: the new bundle goes directly to the output register.
  - Throughput is 1 bundle/cycle whenever out_ready is held at 1.
- Bundles with in_valid=1 but in_lane_valid=0 are accepted and dropped; they produce no output.
- Flush:
  - Same cycle: incoming bundle ignored.
  - Next cycle: out_valid=0, skid empty, in_ready=1.
  - fault_cnt is unaffected.
  - flush has priority over all transfers.
- fault_cnt:
  - Increments by 1 on each accepted, non-flushed bundle containing a valid faulting lane.
  - Saturates at 2^CNT_W-1 and does not wrap.
- rst mid-operation: all held bundles are discarded and the reset values apply.

Optional Feature:
- Macro: DECODE_STAGE_ONEHOT_FU_EN.
- Defined: an extra output port out_fu_mask (LANES*4) is added. It carries a per-lane one-hot functional-unit vector {NONE, INTALU, rsvd, rsvd}, registered alongside out_dec so it has identical latency. Invalid lanes read 4'b0000.
- Undefined: the port is absent and no extra logic is built.

Test Plan:
- Single lane, LANES=2, in_lane_valid=2'b01: ARITHI funct3=ADD rd=1 rs1=2 imm=12'hFFF → next cycle out_valid=1, out_dec[0] has fu=INTALU, op=ADD, immValid=1, imm=32'hFFFF_FFFF, rs2=0; out_lane_valid=2'b01.
- Full bundle: lane0 ARITH SUB rd=3 rs1=4 rs2=5, lane1 ARITHI XOR imm=12'h07F → out_lane_valid=2'b11, lane1 imm=32'h0000_007F, lane0 rs2=5; fault_cnt=0.
- Truncation: lane0 has an unknown opcode, lane1 is a valid ADD → out_lane_valid=2'b01, lane0 ex=EX_DECODE, lane1 dec=0, fault_cnt=1.
- Backpressure: out_ready=0 while 3 bundles are offered back-to-back → first two accepted, in_ready=0 on the third cycle. Raise out_ready → bundles emerge in order with no loss or duplication.
- Flush: with output and skid both full, pulse flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed bundle never appears.
- Saturation: CNT_W=2, 5 faulting bundles → fault_cnt sequence 1,2,3,3,3.
